// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix operand fetch stage: widths, opcode values,
// FSM state encoding and element bit-offset helper.
package matrix_pkg;

  localparam int MAT_W  = 256;
  localparam int ELEM_W = 16;
  localparam int N_ELEM = 16;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_EXEC  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Element k (row*4 + col) occupies bits k*ELEM_W +: ELEM_W of a packed matrix.
  function automatic logic [7:0] elem_off(input logic [3:0] k);
    return 8'(k) * 8'(ELEM_W);
  endfunction

endpackage

// File: rtl/matrix_fetch_addr_gen.sv
// Read-issue sequencer: 32 consecutive reads, elements of matrix 1 then
// matrix 2, each from its own base with mod 2^AW address wrap.
module fetch_addr_gen #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic [AW-1:0] src1_addr,
  input  logic [AW-1:0] src2_addr,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  output logic [4:0]    issue_idx,
  output logic          last_issue
);

  logic [4:0]    cnt_q, cnt_d;
  logic          rd_q, rd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] base1_q, base1_d;
  logic [AW-1:0] base2_q, base2_d;

  always_comb begin
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    base1_d = base1_q;
    base2_d = base2_q;
    if (start_i) begin
      base1_d = src1_addr;
      base2_d = src2_addr;
      cnt_d   = 5'd0;
      rd_d    = 1'b1;
      addr_d  = src1_addr;
    end else if (rd_q) begin
      if (cnt_q == 5'd31) begin
        rd_d  = 1'b0;
        cnt_d = 5'd0;
      end else begin
        cnt_d  = cnt_q + 5'd1;
        // Bit 4 of the index picks the matrix; the sum wraps naturally at AW bits.
        addr_d = (cnt_d[4] ? base2_q : base1_q) + AW'(cnt_d[3:0]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= 5'd0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      base1_q <= '0;
      base2_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      base1_q <= base1_d;
      base2_q <= base2_d;
    end
  end

  assign mem_rd     = rd_q;
  assign mem_addr   = addr_q;
  assign issue_idx  = cnt_q;
  assign last_issue = rd_q && (cnt_q == 5'd31);

endmodule

// File: rtl/matrix_fetch.sv
// Operand fetch stage: loads two packed 4x4 matrices from operand memory and
// drives them with enable into the add/sub unit for EXEC_CYCLES cycles.
module matrix_fetch
  import matrix_pkg::*;
#(
  parameter int EXEC_CYCLES = 2,
  parameter int AW          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [AW-1:0]    src1_addr,
  input  logic [AW-1:0]    src2_addr,
  output logic             mem_rd,
  output logic [AW-1:0]    mem_addr,
  input  logic [15:0]      mem_data,
  output logic [MAT_W-1:0] m1,
  output logic [MAT_W-1:0] m2,
  output logic             select_op,
  output logic             enable,
  output logic             busy,
  output logic             done,
  output logic [2:0]       dbg_state
);

  // start/done handshake: start is taken only in IDLE (busy low) and is
  // otherwise dropped, never queued; done is a single-cycle pulse after which
  // busy falls and the next start can be accepted.

  state_e     state_q, state_d;
  logic       sel_q, sel_d;
  logic       en_q, en_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] exec_cnt_q, exec_cnt_d;

  logic             cap_en_q, cap_en_d;
  logic [4:0]       cap_idx_q, cap_idx_d;
  logic [MAT_W-1:0] m1_q, m1_d;
  logic [MAT_W-1:0] m2_q, m2_d;

  logic       accept;
  logic [4:0] issue_idx;
  logic       last_issue;

  assign accept = (state_q == ST_IDLE) && start;

  fetch_addr_gen #(.AW(AW)) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .start_i    (accept),
    .src1_addr  (src1_addr),
    .src2_addr  (src2_addr),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .issue_idx  (issue_idx),
    .last_issue (last_issue)
  );

  // Capture trails issue by one cycle because read data arrives a cycle late.
  always_comb begin
    cap_en_d  = mem_rd;
    cap_idx_d = issue_idx;
    m1_d      = m1_q;
    m2_d      = m2_q;
    if (cap_en_q) begin
      if (cap_idx_q < 5'(N_ELEM)) m1_d[elem_off(cap_idx_q[3:0]) +: ELEM_W] = mem_data;
      else                        m2_d[elem_off(cap_idx_q[3:0]) +: ELEM_W] = mem_data;
    end
  end

  // DRAIN doubles as the first enable cycle so start-to-done is 33+EXEC_CYCLES;
  // the last m2 element lands at the end of that cycle, before the unit's final sample.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    en_d       = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    exec_cnt_d = exec_cnt_q;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d = ST_LOAD;
          busy_d  = 1'b1;
          sel_d   = (op == OP_SUB) ? OP_SUB : OP_ADD;
        end
      end
      ST_LOAD: begin
        if (last_issue) begin
          state_d    = ST_DRAIN;
          en_d       = 1'b1;
          exec_cnt_d = 4'd1;
        end
      end
      ST_DRAIN, ST_EXEC: begin
        if (exec_cnt_q == 4'(EXEC_CYCLES)) begin
          state_d    = ST_DONE;
          done_d     = 1'b1;
          exec_cnt_d = 4'd0;
        end else begin
          state_d    = ST_EXEC;
          en_d       = 1'b1;
          exec_cnt_d = exec_cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      sel_q      <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      exec_cnt_q <= 4'd0;
      cap_en_q   <= 1'b0;
      cap_idx_q  <= 5'd0;
      m1_q       <= '0;
      m2_q       <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      exec_cnt_q <= exec_cnt_d;
      cap_en_q   <= cap_en_d;
      cap_idx_q  <= cap_idx_d;
      m1_q       <= m1_d;
      m2_q       <= m2_d;
    end
  end

  assign m1        = m1_q;
  assign m2        = m2_q;
  assign select_op = sel_q;
  assign enable    = en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
